pll_rst_ctrl: RTL and testbench

PLL_RST_CTRL -- requirements
Module: pll_rst_ctrl

---
 rtl/pll_rst_ctrl.sv | 138 +++++++++++++
 tb/tb_pll_rst_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_rst_ctrl.sv
// PLL reset sequencer: pulses the PLL reset, waits for a stable lock,
// then releases the system reset; retries on lock timeout.
module pll_rst_ctrl #(
    parameter int unsigned RST_CYC      = 16,
    parameter int unsigned LOCK_TIMEOUT = 50000,
    parameter int unsigned STABLE_CYC   = 1024,
    parameter int unsigned HOLD_CYC     = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pll_lock,
    output logic       pll_rst,
    output logic       sys_rst_n,
    output logic       locked,
    output logic [7:0] retry_cnt,
    output logic       lock_lost
);

    typedef enum logic [2:0] {
        S_PLL_RST,
        S_WAIT_LOCK,
        S_STABLE,
        S_HOLD,
        S_RUN
    } state_e;

    localparam logic [15:0] RST_LAST = 16'(RST_CYC - 1);
    localparam logic [15:0] TMO_LAST = 16'(LOCK_TIMEOUT - 1);
    localparam logic [15:0] STB_LAST = 16'(STABLE_CYC - 1);
    localparam logic [15:0] HLD_LAST = 16'(HOLD_CYC - 1);

    state_e      state_q;
    logic [15:0] cnt_q;
    logic [15:0] cnt_d;
    logic [1:0]  sync_q;
    logic        lock_s;
    logic        pll_rst_q;
    logic        sys_rst_n_q;
    logic        locked_q;
    logic [7:0]  retry_q;
    logic        lost_q;

    assign lock_s = sync_q[1];
    assign cnt_d  = cnt_q + 16'd1;

    // Two-flop synchroniser for the asynchronous PLL lock flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], pll_lock};
        end
    end

    // Sequencer FSM with shared phase counter and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_PLL_RST;
            cnt_q       <= '0;
            pll_rst_q   <= 1'b1;
            sys_rst_n_q <= 1'b0;
            locked_q    <= 1'b0;
            retry_q     <= '0;
            lost_q      <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            unique case (state_q)
                S_PLL_RST: begin
                    if (cnt_q == RST_LAST) begin
                        state_q   <= S_WAIT_LOCK;
                        cnt_q     <= '0;
                        pll_rst_q <= 1'b0;
                    end
                end
                S_WAIT_LOCK: begin
                    if (lock_s) begin
                        state_q <= S_STABLE;
                        cnt_q   <= '0;
                    end else if (cnt_q == TMO_LAST) begin
                        state_q   <= S_PLL_RST;
                        cnt_q     <= '0;
                        pll_rst_q <= 1'b1;
                        if (retry_q != 8'hFF) begin
                            retry_q <= retry_q + 8'd1;
                        end
                    end
                end
                S_STABLE: begin
                    if (!lock_s) begin
                        state_q <= S_WAIT_LOCK;
                        cnt_q   <= '0;
                    end else if (cnt_q == STB_LAST) begin
                        state_q <= S_HOLD;
                        cnt_q   <= '0;
                    end
                end
                S_HOLD: begin
                    if (!lock_s) begin
                        state_q   <= S_PLL_RST;
                        cnt_q     <= '0;
                        pll_rst_q <= 1'b1;
                    end else if (cnt_q == HLD_LAST) begin
                        state_q     <= S_RUN;
                        cnt_q       <= '0;
                        sys_rst_n_q <= 1'b1;
                        locked_q    <= 1'b1;
                    end
                end
                S_RUN: begin
                    // counter parks here so it never wraps
                    cnt_q <= cnt_q;
                    if (!lock_s) begin
                        state_q     <= S_PLL_RST;
                        cnt_q       <= '0;
                        pll_rst_q   <= 1'b1;
                        sys_rst_n_q <= 1'b0;
                        locked_q    <= 1'b0;
                        lost_q      <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= S_PLL_RST;
                    cnt_q       <= '0;
                    pll_rst_q   <= 1'b1;
                    sys_rst_n_q <= 1'b0;
                    locked_q    <= 1'b0;
                end
            endcase
        end
    end

    assign pll_rst   = pll_rst_q;
    assign sys_rst_n = sys_rst_n_q;
    assign locked    = locked_q;
    assign retry_cnt = retry_q;
    assign lock_lost = lost_q;

endmodule

// File: tb/tb_pll_rst_ctrl.sv
// Bench for pll_rst_ctrl: directed sequences plus random lock
// toggling against a phase/duration reference model.
`timescale 1ns/1ps
module tb_pll_rst_ctrl;

    localparam int RST_CYC      = 16;
    localparam int LOCK_TIMEOUT = 200;
    localparam int STABLE_CYC   = 32;
    localparam int HOLD_CYC     = 8;

    localparam int P_RST  = 0;
    localparam int P_WAIT = 1;
    localparam int P_STAB = 2;
    localparam int P_HOLD = 3;
    localparam int P_RUN  = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pll_lock = 1'b0;
    logic       pll_rst;
    logic       sys_rst_n;
    logic       locked;
    logic [7:0] retry_cnt;
    logic       lock_lost;

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 1'b1;

    pll_rst_ctrl #(
        .RST_CYC     (RST_CYC),
        .LOCK_TIMEOUT(LOCK_TIMEOUT),
        .STABLE_CYC  (STABLE_CYC),
        .HOLD_CYC    (HOLD_CYC)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .pll_lock (pll_lock),
        .pll_rst  (pll_rst),
        .sys_rst_n(sys_rst_n),
        .locked   (locked),
        .retry_cnt(retry_cnt),
        .lock_lost(lock_lost)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: phase, cycles spent in it, lock history
    int m_ph = P_RST;
    int m_n = 0;
    int m_retry = 0;
    bit m_lost = 1'b0;
    bit m_s1 = 1'b0;
    bit m_s2 = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ph    <= P_RST;
            m_n     <= 0;
            m_retry <= 0;
            m_lost  <= 1'b0;
            m_s1    <= 1'b0;
            m_s2    <= 1'b0;
        end else begin : step
            int np;
            int done;
            bit ls;
            ls   = m_s2;
            np   = m_ph;
            done = m_n + 1;
            case (m_ph)
                P_RST: if (done >= RST_CYC) np = P_WAIT;
                P_WAIT: begin
                    if (ls) np = P_STAB;
                    else if (done >= LOCK_TIMEOUT) begin
                        np = P_RST;
                        m_retry <= (m_retry < 255) ? m_retry + 1 : 255;
                    end
                end
                P_STAB: begin
                    if (!ls) np = P_WAIT;
                    else if (done >= STABLE_CYC) np = P_HOLD;
                end
                P_HOLD: begin
                    if (!ls) np = P_RST;
                    else if (done >= HOLD_CYC) np = P_RUN;
                end
                default: begin
                    if (!ls) begin
                        np = P_RST;
                        m_lost <= 1'b1;
                    end
                end
            endcase
            m_ph <= np;
            m_n  <= (np == m_ph) ? done : 0;
            m_s1 <= pll_lock;
            m_s2 <= m_s1;
        end
    end

    logic [11:0] dut_v;
    logic [11:0] exp_v;
    assign dut_v = {pll_rst, sys_rst_n, locked, lock_lost, retry_cnt};
    assign exp_v = {m_ph == P_RST, m_ph == P_RUN, m_ph == P_RUN,
                    m_lost, 8'(m_retry)};

    // Per-cycle comparison against the model plus output invariants
    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            chk("model", 32'(dut_v), 32'(exp_v));
            chk("excl", 32'(pll_rst & sys_rst_n), 0);
            chk("xprop", 32'($isunknown(dut_v)), 0);
        end
    end

    // Count posedges until the chosen output (0 pll_rst, 1 sys_rst_n)
    // reaches val; an expired budget is reported as a failure.
    task automatic wait_sig(input int which, input logic val,
                            input int maxc, input string tag,
                            output int n);
        logic cur;
        bit hit;
        n = 0;
        hit = 1'b0;
        while (!hit && n < maxc) begin
            @(posedge clk);
            #1;
            n++;
            cur = (which == 0) ? pll_rst : sys_rst_n;
            if (cur === val) hit = 1'b1;
        end
        if (!hit) chk({tag, "_timeout"}, 0, 1);
    endtask

    task automatic drop_one;
        @(negedge clk);
        pll_lock = 1'b0;
        @(negedge clk);
        pll_lock = 1'b1;
    endtask

    localparam int LAT = STABLE_CYC + HOLD_CYC + 3;
    localparam int SEQ = RST_CYC + LAT + 20;

    initial begin
        int n;
        int d;
        int dly;

        rst_n = 1'b0;
        pll_lock = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_prst", 32'(pll_rst), 1);
        chk("rst_sys", 32'(sys_rst_n), 0);
        chk("rst_lock", 32'(locked), 0);
        chk("rst_retry", 32'(retry_cnt), 0);
        chk("rst_lost", 32'(lock_lost), 0);
        rst_n = 1'b1;

        // Clean bring-up: lock 100 cycles after pll_rst falls
        wait_sig(0, 1'b0, 100, "bring_prst", n);
        chk("rst_len", n, RST_CYC);
        repeat (100) @(negedge clk);
        pll_lock = 1'b1;
        wait_sig(1, 1'b1, LAT + 20, "bring_sys", n);
        chk("lock_lat", n, LAT);
        chk("run_locked", 32'(locked), 1);
        chk("run_retry", 32'(retry_cnt), 0);
        chk("run_lost", 32'(lock_lost), 0);

        // One-cycle lock loss in RUN
        drop_one();
        wait_sig(1, 1'b0, 10, "drop_sys", n);
        chk("drop_lat", 32'((n + 1) <= 4), 1);
        chk("lost_set", 32'(lock_lost), 1);
        wait_sig(0, 1'b0, RST_CYC + 10, "drop_prst", n);
        chk("repulse_len", n, RST_CYC);
        wait_sig(1, 1'b1, SEQ, "drop_rerun", n);
        chk("lost_sticky", 32'(lock_lost), 1);
        chk("rerun_locked", 32'(locked), 1);

        // Short lock glitch while in STABLE
        drop_one();
        wait_sig(1, 1'b0, 10, "gl_sys", n);
        wait_sig(0, 1'b0, RST_CYC + 10, "gl_prst", n);
        repeat (15) @(negedge clk);
        pll_lock = 1'b0;
        repeat (3) @(negedge clk);
        pll_lock = 1'b1;
        wait_sig(1, 1'b1, LAT + 20, "gl_rec", n);
        chk("glitch_lat", n, LAT);
        chk("glitch_retry", 32'(retry_cnt), 0);

        // Asynchronous reset in the middle of HOLD
        drop_one();
        wait_sig(1, 1'b0, 10, "hr_sys", n);
        wait_sig(0, 1'b0, RST_CYC + 10, "hr_prst", n);
        repeat (STABLE_CYC + 3) @(posedge clk);
        #2;
        chk("hold_sys", 32'(sys_rst_n), 0);
        chk("hold_prst", 32'(pll_rst), 0);
        chk("hold_lost", 32'(lock_lost), 1);
        rst_n = 1'b0;
        #1;
        chk("arst_prst", 32'(pll_rst), 1);
        chk("arst_sys", 32'(sys_rst_n), 0);
        chk("arst_lock", 32'(locked), 0);
        chk("arst_retry", 32'(retry_cnt), 0);
        chk("arst_lost", 32'(lock_lost), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Random lock toggling at arbitrary offsets inside the cycle
        for (int s = 0; s < 150; s++) begin
            d = $urandom_range(1, 100);
            @(posedge clk);
            dly = $urandom_range(1, 9);
            #(dly);
            pll_lock = ~pll_lock;
            repeat (d) @(posedge clk);
        end

        // Lock never arrives: retry cadence and saturation
        @(negedge clk);
        rst_n = 1'b0;
        pll_lock = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        wait_sig(0, 1'b0, RST_CYC + 10, "sat_rst", n);
        chk("sat_rst_len", n, RST_CYC);
        for (int k = 1; k <= 3; k++) begin
            wait_sig(0, 1'b1, LOCK_TIMEOUT + 10, "sat_rise", n);
            chk("wait_len", n, LOCK_TIMEOUT);
            chk("retry_k", 32'(retry_cnt), 32'(k));
            wait_sig(0, 1'b0, RST_CYC + 10, "sat_fall", n);
            chk("pulse_len", n, RST_CYC);
        end
        chk_en = 1'b0;
        for (int k = 4; k <= 260; k++) begin
            wait_sig(0, 1'b1, LOCK_TIMEOUT + 10, "sat_rise", n);
            wait_sig(0, 1'b0, RST_CYC + 10, "sat_fall", n);
        end
        chk("retry_sat", 32'(retry_cnt), 255);
        chk("retry_model", 32'(retry_cnt), 32'(m_retry));
        chk("sat_sys", 32'(sys_rst_n), 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end

endmodule
